// File: rtl/fwd_ctrl_unit_pkg.sv
// fwd_ctrl_unit_pkg: operand-select codes and default register-address width
package fwd_ctrl_unit_pkg;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam int REG_ADDR_W_DEF = 5;
endpackage

// File: rtl/fwd_src_sel.sv
// fwd_src_sel: youngest-producer-first select code for one source operand
module fwd_src_sel
  import fwd_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_rw,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_rw,
  output logic [1:0]            sel
);
  logic ex_hit;
  logic mem_hit;
  always_comb begin
    ex_hit  = ex_rw && (ex_rd != '0) && (ex_rd == rs);
    mem_hit = mem_rw && (mem_rd != '0) && (mem_rd == rs);
    sel     = ex_hit ? FWD_EXMEM : mem_hit ? FWD_MEMWB : FWD_RF;
  end
endmodule

// File: rtl/fwd_ctrl_unit.sv
// fwd_ctrl_unit: tracks EX/MEM/WB destinations, registers forwarding selects, flags load-use stalls
module fwd_ctrl_unit
  import fwd_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  pipe_en,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall
);
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
  logic ex_rw_q, ex_rw_d, ex_mr_q, ex_mr_d, mem_rw_q, mem_rw_d, wb_rw_q, wb_rw_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
  logic bubble;
  fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .rs(id_rs1), .ex_rd(ex_rd_q), .ex_rw(ex_rw_q),
    .mem_rd(mem_rd_q), .mem_rw(mem_rw_q), .sel(sel_a)
  );
  fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .rs(id_rs2), .ex_rd(ex_rd_q), .ex_rw(ex_rw_q),
    .mem_rd(mem_rd_q), .mem_rw(mem_rw_q), .sel(sel_b)
  );
  // a load in EX cannot forward yet, so a dependent ID instruction must wait one cycle
  always_comb begin
    stall    = ex_mr_q && (ex_rd_q != '0) && id_valid &&
               ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    bubble   = flush || stall || !id_valid;
    wb_rd_d  = pipe_en ? mem_rd_q : wb_rd_q;
    wb_rw_d  = pipe_en ? mem_rw_q : wb_rw_q;
    mem_rd_d = pipe_en ? ex_rd_q : mem_rd_q;
    mem_rw_d = pipe_en ? ex_rw_q : mem_rw_q;
    ex_rd_d  = !pipe_en ? ex_rd_q : bubble ? '0 : id_rd;
    ex_rw_d  = !pipe_en ? ex_rw_q : bubble ? 1'b0 : id_reg_write;
    ex_mr_d  = !pipe_en ? ex_mr_q : bubble ? 1'b0 : id_mem_read;
    fwd_a_d  = !pipe_en ? fwd_a_q : bubble ? FWD_RF : sel_a;
    fwd_b_d  = !pipe_en ? fwd_b_q : bubble ? FWD_RF : sel_b;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ex_rd_q  <= '0;
      ex_rw_q  <= 1'b0;
      ex_mr_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_rw_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_rw_q  <= 1'b0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_rw_q  <= ex_rw_d;
      ex_mr_q  <= ex_mr_d;
      mem_rd_q <= mem_rd_d;
      mem_rw_q <= mem_rw_d;
      wb_rd_q  <= wb_rd_d;
      wb_rw_q  <= wb_rw_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end
  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// tb_fwd_ctrl_unit: directed forwarding, load-use, freeze, flush and reset scenarios
module tb_fwd_ctrl_unit;
  logic clk = 1'b0;
  logic arst_n, pipe_en, flush, id_valid, id_reg_write, id_mem_read;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a, fwd_b;
  logic stall;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fwd_ctrl_unit dut (
    .clk(clk), .arst_n(arst_n), .pipe_en(pipe_en), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
  );
  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask
  initial begin
    arst_n = 1'b0; pipe_en = 1'b1; flush = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    #12;
    chk("reset_fwd_a", fwd_a, 2'b00);
    chk("reset_fwd_b", fwd_b, 2'b00);
    chk("reset_stall", {1'b0, stall}, 2'b00);
    arst_n = 1'b1;
    tick();
    drive(1, 1, 2, 5, 1, 0); tick();
    drive(1, 5, 6, 8, 1, 0); tick();
    chk("b2b_fwd_a", fwd_a, 2'b10);
    chk("b2b_fwd_b", fwd_b, 2'b00);
    drain();
    drive(1, 1, 2, 7, 1, 0); tick();
    drive(1, 11, 12, 10, 1, 0); tick();
    drive(1, 1, 7, 14, 1, 0); tick();
    chk("dist2_fwd_b", fwd_b, 2'b01);
    chk("dist2_fwd_a", fwd_a, 2'b00);
    drain();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 1, 2, 3, 1, 0); tick();
    drive(1, 3, 4, 15, 1, 0); tick();
    chk("double_fwd_a", fwd_a, 2'b10);
    chk("double_fwd_b", fwd_b, 2'b00);
    drain();
    drive(1, 1, 2, 0, 1, 0); tick();
    drive(1, 0, 0, 16, 1, 0);
    chk("x0_stall", {1'b0, stall}, 2'b00);
    tick();
    chk("x0_fwd_a", fwd_a, 2'b00);
    chk("x0_fwd_b", fwd_b, 2'b00);
    drain();
    drive(1, 1, 2, 9, 1, 1); tick();
    drive(1, 1, 9, 4, 1, 0);
    chk("lu_stall_on", {1'b0, stall}, 2'b01);
    tick();
    chk("lu_stall_off", {1'b0, stall}, 2'b00);
    chk("lu_bubble_fwd_b", fwd_b, 2'b00);
    tick();
    chk("lu_fwd_b", fwd_b, 2'b01);
    chk("lu_fwd_a", fwd_a, 2'b00);
    pipe_en = 1'b0;
    drive(1, 4, 2, 13, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_fwd_a", fwd_a, 2'b00);
      chk("frz_fwd_b", fwd_b, 2'b01);
    end
    pipe_en = 1'b1;
    tick();
    chk("unfrz_fwd_a", fwd_a, 2'b10);
    flush = 1'b1;
    drive(1, 13, 13, 17, 1, 0); tick();
    chk("flush_fwd_a", fwd_a, 2'b00);
    chk("flush_fwd_b", fwd_b, 2'b00);
    flush = 1'b0;
    tick();
    chk("post_flush_fwd_a", fwd_a, 2'b01);
    drain();
    drive(1, 1, 3, 2, 1, 0); tick();
    drive(1, 2, 3, 9, 1, 1); tick();
    chk("pre_rst_fwd_a", fwd_a, 2'b10);
    drive(1, 1, 9, 4, 1, 0);
    chk("pre_rst_stall", {1'b0, stall}, 2'b01);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_mid_stall", {1'b0, stall}, 2'b00);
    chk("rst_mid_fwd_a", fwd_a, 2'b00);
    chk("rst_mid_fwd_b", fwd_b, 2'b00);
    @(negedge clk);
    arst_n = 1'b1;
    drive(1, 2, 9, 4, 1, 0);
    chk("post_rst_stall", {1'b0, stall}, 2'b00);
    tick();
    chk("post_rst_fwd_a", fwd_a, 2'b00);
    chk("post_rst_fwd_b", fwd_b, 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_ctrl_unit.md
FWD_CTRL_UNIT -- requirements
Module: fwd_ctrl_unit

Interface
REQ-001 The module SHALL have parameter REG_ADDR_W, default 5, giving the register-address width.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 arst_n  input  1  reset; asynchronous, active-low.
REQ-004 pipe_en  input  1  pipeline advance enable; 0 freezes all internal state.
REQ-005 flush  input  1  taken-branch kill; the instruction leaving ID enters EX as a bubble.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_rs1, id_rs2  input  REG_ADDR_W  source registers of the ID instruction.
REQ-008 id_rd  input  REG_ADDR_W  destination register of the ID instruction.
REQ-009 id_reg_write, id_mem_read  input  1  ID instruction writes rd / is a load.
REQ-010 fwd_a, fwd_b  output  2  registered operand-select codes for the EX-stage ALU operand muxes.
REQ-011 stall  output  1  combinational load-use hazard; upstream holds PC and IF/ID while it is high.

Function
REQ-012 Select encoding SHALL be: 2'b00 register-file value, 2'b10 EX/MEM result, 2'b01 MEM/WB result. Code 2'b11 SHALL never be driven.
REQ-013 Internal state SHALL be:
  - EX slot: rd, reg_write, mem_read.
  - MEM slot: rd, reg_write.
  - WB slot: rd, reg_write.
REQ-014 The advance condition SHALL be pipe_en=1. On advance:
  - WB slot <= MEM slot.
  - MEM slot <= EX slot.
  - EX slot <= ID fields, or a bubble.
REQ-015 A bubble SHALL set reg_write=0, mem_read=0, rd=0 and fwd_a=fwd_b=2'b00.
REQ-016 The EX slot SHALL receive a bubble when any of the following holds: flush=1, stall=1, or id_valid=0.
REQ-017 The flush bubble SHALL take priority over ID loading. Simultaneous flush and stall SHALL produce a single bubble.
REQ-018 stall SHALL equal 1 when all of the following hold: EX.mem_read=1, EX.rd!=0, id_valid=1, and EX.rd equals id_rs1 or id_rs2. It SHALL not be gated by pipe_en.
REQ-019 On a non-bubble advance, next fwd_a SHALL be computed from id_rs1 in priority order:
  - 2'b10 if EX.reg_write=1, EX.rd!=0 and EX.rd==id_rs1;
  - else 2'b01 if MEM.reg_write=1, MEM.rd!=0 and MEM.rd==id_rs1;
  - else 2'b00.
REQ-020 next fwd_b SHALL follow the same rule as REQ-019 using id_rs2.
REQ-021 EX-slot priority over MEM-slot SHALL guarantee that the youngest producer wins when both match.
REQ-022 Register 0 SHALL never be forwarded, whatever the reg_write flags.
REQ-023 With pipe_en=0, all slots, fwd_a and fwd_b SHALL hold their values; stall SHALL still reflect current state.
REQ-024 A load SHALL never be forwarded from the EX slot. After a one-cycle stall bubble the load sits in MEM, and the consumer SHALL receive 2'b01.
REQ-025 The WB slot SHALL be tracked for observability only and SHALL NOT produce a select code; same-cycle write/read is resolved by the register file.

Reset
REQ-026 On arst_n=0, the following SHALL clear immediately, independent of clk: all slot fields, fwd_a=fwd_b=2'b00, and therefore stall=0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL discard all pending state. The first advance after release SHALL behave as from an empty pipeline.
REQ-028 Reset release SHALL take effect on the first rising clk edge with arst_n=1.

Structure
REQ-029 The shared package SHALL hold:
  - select-code constants FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
  - the default REG_ADDR_W.
REQ-030 A sub-module fwd_src_sel SHALL implement the single-operand priority compare of REQ-019. It SHALL be instantiated twice, once for rs1 and once for rs2.
REQ-031 All state SHALL reside in fwd_ctrl_unit. stall SHALL be the only combinational output.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
  - ALU back-to-back: add x5 in ID, advance, then ID rs1=5 advance -> fwd_a=2'b10 next cycle, fwd_b=2'b00.
  - Distance two: x7 writer, one unrelated instruction, then reader rs2=7 -> fwd_b=2'b01.
  - Double match: x3 written by two consecutive instructions, then reader rs1=3 -> fwd_a=2'b10 (youngest wins).
  - x0: writer rd=0 reg_write=1, reader rs1=0 -> fwd_a=2'b00, stall=0.
  - Load-use: load x9 in EX, ID rs2=9 -> stall=1 for exactly one cycle, then bubble in EX and fwd_b=2'b01 on the following advance.
  - Freeze, flush, reset:
    - pipe_en=0 for 3 cycles holds fwd values;
    - flush with a matching reader -> EX bubble, fwd=2'b00;
    - arst_n low mid-stall -> stall=0 and fwd=2'b00 without a clock edge.
